frame_tick_sched: RTL and testbench
===================================

Name: frame_tick_sched

Overview:
- Receiving end of the 60 Hz divided clock. Brings the slow toggle signal clk_60hz into the clk_50mhz domain and detects its rising edges as frame ticks.
- Runs a frame-start / render-done handshake with the render pipeline. Counts frames and overruns (a tick arriving while the renderer is still busy).
- Watchdog flags a lost or stalled tick source.
- Sits between the clock divider and the render engine top level.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on clk_60hz (min 2)
- FRAME_W, 16, width of frame_count
- OVR_W, 8, width of overrun_count (saturating)
- TIMEOUT, 1000000, clk_50mhz cycles without a tick before tick_lost asserts (nominal tick period is 833,334 cycles)
- TMO_W, 20, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT

Ports:
- clk_50mhz  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_60hz  in  1  divided toggle clock, treated as asynchronous data
- render_done  in  1  one-cycle pulse from renderer: current frame finished
- frame_start  out  1  one-cycle pulse: renderer may begin a new frame
- rendering  out  1  high while a frame is outstanding (state RENDER)
- frame_count  out  FRAME_W  number of frame_start pulses issued, wraps
- overrun_count  out  OVR_W  ticks dropped while RENDER, saturates at all-ones
- tick_lost  out  1  sticky watchdog flag, cleared by the next tick

Behaviour:
- Reset: Reset is rst_n, asynchronous, active-low; clock is clk_50mhz. Reset clears all sync flops, the edge-history flop and the watchdog counter to 0, and sets state IDLE. All outputs are 0.
- Sync chain:
  - SYNC_STAGES flops feed the last-stage value q and the history flop p.
  - tick = q & ~p (rising edge only).
  - Falling edges are ignored.
- Latency (SYNC_STAGES=2): clk_60hz is first sampled high at edge E0. q goes high after E1. frame_start is registered, high for exactly the cycle after E2, and low after E3.
- FSM (2 states):
  - IDLE: on tick, go to RENDER, pulse frame_start, and increment frame_count. render_done is ignored.
  - RENDER, render_done only: go to IDLE.
  - RENDER, tick only: stay in RENDER. No frame_start. overrun_count += 1, saturating at 2^OVR_W-1.
  - RENDER, tick and render_done in the same cycle: done wins, then the new frame starts. Stay in RENDER, pulse frame_start, increment frame_count. overrun_count is unchanged.
- rendering = (state == RENDER), registered output.
- frame_count wraps from 2^FRAME_W-1 to 0.
- Watchdog:
  - The counter clears to 0 on tick; otherwise it increments and saturates at TIMEOUT.
  - tick_lost sets in the cycle the counter reaches TIMEOUT and stays set.
  - The next tick clears tick_lost in the same cycle it issues or drops frame_start.
  - The watchdog runs in both FSM states.
- Mid-operation reset: all state is lost immediately. No frame_start follows reset unless a fresh rising edge is detected afterwards; p resets to 0, so an input already high at reset release yields one tick.
- frame_start never asserts on two consecutive cycles.

Decomposition:
- Shared render package holds:
  - state encoding constants (ST_IDLE=0, ST_RENDER=1)
  - CLK_DIV_HALF_PERIOD=416667
  - default TIMEOUT
  - FRAME_W default
- One sub-module: sync_rise_det (parameterised SYNC_STAGES synchronizer plus rising-edge detector, output tick). frame_tick_sched instantiates it and contains the FSM, counters and watchdog.

Test Plan:
- Reset: hold rst_n=0 with clk_60hz=0 -> all outputs 0. Release, run 1000 cycles with no edge -> outputs remain 0.
- Single frame: raise clk_60hz just before edge E0 -> frame_start high only in the cycle after E2, frame_count=1, rendering=1. Pulse render_done 50 cycles later -> rendering=0 next cycle.
- Overrun: 3 rising edges 20 cycles apart, no render_done -> frame_count=1, overrun_count=2. Then 300 more edges -> overrun_count=255 (saturated).
- Simultaneous: in RENDER, align render_done with the tick cycle -> rendering stays 1, frame_start pulses, frame_count increments, overrun_count unchanged.
- Watchdog (TIMEOUT=100 override): no edges -> tick_lost=1 at cycle 100 after reset and stays set. Next rising edge -> tick_lost=0 in the frame_start cycle.
- Reset mid-render: assert rst_n=0 while rendering=1 and clk_60hz=1, release with clk_60hz still 1 -> exactly one frame_start ~3 cycles later, frame_count=1.

Source files
------------

// File: rtl/frame_tick_sched_pkg.sv
// Shared render-side constants: FSM state encoding and clock divider / watchdog defaults.
// No logic; imported by the tick scheduler and its interface users.
package frame_tick_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RENDER = 1'b1
  } state_t;

  localparam int CLK_DIV_HALF_PERIOD = 416667;
  localparam int DEFAULT_TIMEOUT     = 1000000;
  localparam int DEFAULT_TMO_W       = 20;
  localparam int DEFAULT_FRAME_W     = 16;
  localparam int DEFAULT_OVR_W       = 8;

endpackage

// File: rtl/frame_tick_sched_if.sv
// Scheduler <-> renderer handshake bundle: frame_start/render_done plus status counters.
// The master modport is the scheduler; the slave modport is the render engine.
interface frame_tick_sched_if
  import frame_tick_sched_pkg::*;
#(
  parameter int FRAME_W = DEFAULT_FRAME_W,
  parameter int OVR_W   = DEFAULT_OVR_W
);
  logic               render_done;
  logic               frame_start;
  logic               rendering;
  logic [FRAME_W-1:0] frame_count;
  logic [OVR_W-1:0]   overrun_count;
  logic               tick_lost;

  modport master (
    input  render_done,
    output frame_start, rendering, frame_count, overrun_count, tick_lost
  );

  modport slave (
    output render_done,
    input  frame_start, rendering, frame_count, overrun_count, tick_lost
  );
endinterface

// File: rtl/frame_tick_sched_sync_rise_det.sv
// Synchronizes an asynchronous slow toggle into clk_50mhz and flags its rising edges.
// tick is combinational from flops, valid SYNC_STAGES cycles after sampling; no backpressure.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
    tick   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // History resets low so an input already high at reset release yields one tick.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
endmodule

// File: rtl/frame_tick_sched.sv
// Turns 60 Hz ticks into frame_start pulses, counting frames/overruns, with a lost-tick watchdog.
// frame_start is registered one cycle after the tick; a busy renderer drops ticks (counted), never stalls.
module frame_tick_sched
  import frame_tick_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_W     = DEFAULT_FRAME_W,
  parameter int OVR_W       = DEFAULT_OVR_W,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int TMO_W       = DEFAULT_TMO_W
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_n,
  input  logic                  clk_60hz,
  frame_tick_sched_if.master    bus
);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic               tick;
  state_t             state_q, state_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic [OVR_W-1:0]   overrun_count_q, overrun_count_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               tick_lost_q, tick_lost_d;

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .async_in  (clk_60hz),
    .tick      (tick)
  );

  always_comb begin
    state_d         = state_q;
    frame_start_d   = 1'b0;
    frame_count_d   = frame_count_q;
    overrun_count_d = overrun_count_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d       = ST_RENDER;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + FRAME_W'(1);
        end
      end
      ST_RENDER: begin
        // A done coinciding with a tick retires the old frame and starts the next.
        if (tick && bus.render_done) begin
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + FRAME_W'(1);
        end else if (bus.render_done) begin
          state_d = ST_IDLE;
        end else if (tick && (overrun_count_q != '1)) begin
          overrun_count_d = overrun_count_q + OVR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wdog_d      = wdog_q;
    tick_lost_d = tick_lost_q;
    if (tick) begin
      wdog_d      = '0;
      tick_lost_d = 1'b0;
    end else begin
      if (wdog_q != TMO_MAX) wdog_d = wdog_q + TMO_W'(1);
      if (wdog_d == TMO_MAX) tick_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      frame_start_q   <= 1'b0;
      frame_count_q   <= '0;
      overrun_count_q <= '0;
      wdog_q          <= '0;
      tick_lost_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_start_q   <= frame_start_d;
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
      wdog_q          <= wdog_d;
      tick_lost_q     <= tick_lost_d;
    end
  end

  assign bus.frame_start   = frame_start_q;
  assign bus.rendering     = (state_q == ST_RENDER);
  assign bus.frame_count   = frame_count_q;
  assign bus.overrun_count = overrun_count_q;
  assign bus.tick_lost     = tick_lost_q;
endmodule

// File: tb/tb_frame_tick_sched.sv
// Directed bench: dut_a (FRAME_W=4, default watchdog) for frame/overrun/wrap behaviour,
// dut_b (TIMEOUT=100) sharing the same stimulus for the watchdog.
module tb_frame_tick_sched;
  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b0;
  logic clk_60hz  = 1'b0;
  logic rd        = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  frame_tick_sched_if #(.FRAME_W(4), .OVR_W(8)) bus_a ();
  frame_tick_sched_if #(.FRAME_W(16), .OVR_W(8)) bus_b ();
  assign bus_a.render_done = rd;
  assign bus_b.render_done = rd;

  frame_tick_sched #(.SYNC_STAGES(2), .FRAME_W(4), .OVR_W(8), .TIMEOUT(1000000), .TMO_W(20)) dut_a (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .clk_60hz  (clk_60hz),
    .bus       (bus_a)
  );

  frame_tick_sched #(.SYNC_STAGES(2), .FRAME_W(16), .OVR_W(8), .TIMEOUT(100), .TMO_W(7)) dut_b (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .clk_60hz  (clk_60hz),
    .bus       (bus_b)
  );

  logic fs_prev     = 1'b0;
  bit   consec_seen = 1'b0;
  always @(negedge clk_50mhz) begin
    if (bus_a.frame_start && fs_prev) consec_seen = 1'b1;
    fs_prev = bus_a.frame_start;
  end

  typedef struct {
    bit c60;
    bit rdone;
    int ncyc;
    int exp_fs;
    int exp_rend;
    int exp_fc;
    int exp_ov;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic edge60(input int hi, input int lo);
    clk_60hz = 1'b1;
    cyc(hi);
    clk_60hz = 1'b0;
    cyc(lo);
  endtask

  task automatic one_frame();
    clk_60hz = 1'b1;
    cyc(4);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    clk_60hz = 1'b0;
    cyc(4);
  endtask

  initial begin
    int first_fs;
    int fs_cnt;

    //            c60 rd ncyc fs rend fc ov
    vecs[0]  = '{1, 0, 1,  0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1,  0, 0, 0, 0};
    vecs[2]  = '{1, 0, 1,  1, 1, 1, 0};
    vecs[3]  = '{1, 0, 1,  0, 1, 1, 0};
    vecs[4]  = '{1, 0, 47, 0, 1, 1, 0};
    vecs[5]  = '{1, 1, 1,  0, 0, 1, 0};
    vecs[6]  = '{0, 0, 1,  0, 0, 1, 0};
    vecs[7]  = '{0, 0, 5,  0, 0, 1, 0};
    vecs[8]  = '{1, 0, 1,  0, 0, 1, 0};
    vecs[9]  = '{1, 0, 1,  0, 0, 1, 0};
    vecs[10] = '{1, 0, 1,  1, 1, 2, 0};
    vecs[11] = '{1, 0, 1,  0, 1, 2, 0};
    vecs[12] = '{0, 0, 4,  0, 1, 2, 0};
    vecs[13] = '{1, 0, 1,  0, 1, 2, 0};
    vecs[14] = '{1, 0, 1,  0, 1, 2, 0};
    vecs[15] = '{1, 1, 1,  1, 1, 3, 0};
    vecs[16] = '{1, 0, 1,  0, 1, 3, 0};
    vecs[17] = '{0, 0, 3,  0, 1, 3, 0};
    vecs[18] = '{1, 0, 1,  0, 1, 3, 0};
    vecs[19] = '{1, 0, 1,  0, 1, 3, 0};
    vecs[20] = '{1, 0, 1,  0, 1, 3, 1};
    vecs[21] = '{1, 0, 1,  0, 1, 3, 1};

    // Reset held with input low
    cyc(3);
    chk("rst_frame_start", int'(bus_a.frame_start), 0);
    chk("rst_rendering", int'(bus_a.rendering), 0);
    chk("rst_frame_count", int'(bus_a.frame_count), 0);
    chk("rst_overrun", int'(bus_a.overrun_count), 0);
    chk("rst_tick_lost_a", int'(bus_a.tick_lost), 0);
    chk("rst_tick_lost_b", int'(bus_b.tick_lost), 0);
    rst_n = 1'b1;

    // Watchdog with no edges, dut_b TIMEOUT=100
    cyc(99);
    chk("wdog_before_timeout", int'(bus_b.tick_lost), 0);
    cyc(1);
    chk("wdog_at_timeout", int'(bus_b.tick_lost), 1);
    cyc(900);
    chk("wdog_sticky", int'(bus_b.tick_lost), 1);
    chk("idle_frame_start", int'(bus_a.frame_start), 0);
    chk("idle_rendering", int'(bus_a.rendering), 0);
    chk("idle_frame_count", int'(bus_a.frame_count), 0);
    chk("idle_overrun", int'(bus_a.overrun_count), 0);
    chk("idle_tick_lost_a", int'(bus_a.tick_lost), 0);

    // Single frame, falling edge, second frame, simultaneous tick+done, one overrun
    for (int i = 0; i < 22; i++) begin
      clk_60hz = vecs[i].c60;
      rd       = vecs[i].rdone;
      cyc(vecs[i].ncyc);
      rd       = 1'b0;
      chk($sformatf("vec%0d_frame_start", i), int'(bus_a.frame_start), vecs[i].exp_fs);
      chk($sformatf("vec%0d_rendering", i), int'(bus_a.rendering), vecs[i].exp_rend);
      chk($sformatf("vec%0d_frame_count", i), int'(bus_a.frame_count), vecs[i].exp_fc);
      chk($sformatf("vec%0d_overrun", i), int'(bus_a.overrun_count), vecs[i].exp_ov);
      if (i == 2) begin
        chk("wdog_clear_fs", int'(bus_b.frame_start), 1);
        chk("wdog_clear_tick_lost", int'(bus_b.tick_lost), 0);
      end
    end

    // Overrun accumulation and saturation from a fresh reset
    clk_60hz = 1'b0;
    rd       = 1'b0;
    rst_n    = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    repeat (3) edge60(10, 10);
    chk("ovr3_frame_count", int'(bus_a.frame_count), 1);
    chk("ovr3_overrun", int'(bus_a.overrun_count), 2);
    chk("ovr3_rendering", int'(bus_a.rendering), 1);
    repeat (300) edge60(10, 10);
    chk("ovr_sat_overrun", int'(bus_a.overrun_count), 255);
    chk("ovr_sat_frame_count", int'(bus_a.frame_count), 1);

    // frame_count wrap (FRAME_W=4)
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    chk("done_to_idle", int'(bus_a.rendering), 0);
    repeat (14) one_frame();
    chk("wrap_pre_frame_count", int'(bus_a.frame_count), 15);
    one_frame();
    chk("wrap_frame_count", int'(bus_a.frame_count), 0);
    chk("wrap_overrun_held", int'(bus_a.overrun_count), 255);

    // Reset mid-render with input held high across release
    clk_60hz = 1'b1;
    cyc(4);
    chk("mid_rendering", int'(bus_a.rendering), 1);
    rst_n = 1'b0;
    cyc(2);
    chk("mid_rst_rendering", int'(bus_a.rendering), 0);
    chk("mid_rst_frame_count", int'(bus_a.frame_count), 0);
    rst_n = 1'b1;
    first_fs = -1;
    fs_cnt   = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (bus_a.frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = k;
      end
    end
    chk("mid_fs_cycle", first_fs, 3);
    chk("mid_fs_count", fs_cnt, 1);
    chk("mid_frame_count", int'(bus_a.frame_count), 1);

    chk("no_back_to_back_fs", int'(consec_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
